load_store_unit: RTL and testbench

MEM-stage load/store unit sitting directly upstream of the word-addressed data memory (synchronous negedge write, asynchronous read). Accepts one RISC-V load/store request at a time from the pipeline and converts byte, halfword and word accesses into word accesses. Sub-word stores use a read-modify-write. Loads are returned sign- or zero-extended, and misaligned, out-of-range or illegal requests are flagged. Holds the pipeline via req_ready while an access is in flight.

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit in front of a word-addressed data memory.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_RMW   = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [2:0]            r_funct3;
    logic [1:0]            r_byte_off;
    logic [DEPTH_LOG2-1:0] r_word_idx;
    logic [31:0]           r_buf;
    logic                  r_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept       = req_valid && (r_state == c_ST_IDLE);
    assign w_illegal      = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                            (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = |req_addr[31:DEPTH_LOG2+2];
    assign w_err          = w_illegal || w_misaligned || w_out_of_range;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)
                        w_next = c_ST_DONE;
                    else if (!req_we)
                        w_next = c_ST_LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        w_next = c_ST_WRITE;
                    else
                        w_next = c_ST_RMW;
                end
            end
            c_ST_LOAD:  w_next = c_ST_DONE;
            c_ST_RMW:   w_next = c_ST_WRITE;
            c_ST_WRITE: w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == c_ST_IDLE);
        resp_valid = (r_state == c_ST_DONE);
        resp_err   = (r_state == c_ST_DONE) && r_err;
        mem_we     = (r_state == c_ST_WRITE);
        mem_wd     = r_buf;
        mem_addr   = {{(32-DEPTH_LOG2){1'b0}}, r_word_idx};
    end

    // Lane selection for loads; funct3[2] picks zero- over sign-extension
    assign w_byte = mem_rd[{r_byte_off, 3'b000} +: 8];
    assign w_half = mem_rd[{r_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load_data = mem_rd;
        endcase
    end

    // Store lane data sits in the low bits of the buffer until merged
    always_comb begin
        w_merged = mem_rd;
        if (r_funct3[0])
            w_merged[{r_byte_off[1], 4'b0000} +: 16] = r_buf[15:0];
        else
            w_merged[{r_byte_off, 3'b000} +: 8] = r_buf[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3   <= 3'b000;
            r_byte_off <= 2'b00;
            r_word_idx <= '0;
            r_buf      <= 32'h0;
            r_err      <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_funct3   <= req_funct3;
                r_byte_off <= req_addr[1:0];
                r_word_idx <= req_addr[DEPTH_LOG2+1:2];
                r_buf      <= req_wdata;
                r_err      <= w_err;
            end
            if (r_state == c_ST_RMW)
                r_buf <= w_merged;
            if (r_state == c_ST_LOAD)
                resp_rdata <= w_load_data;
            else if ((r_state == c_ST_WRITE) || (w_accept && w_err))
                resp_rdata <= 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a behavioural data memory.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    logic [5:0]  w_idx;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wa;
        logic [31:0] wd;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   nwr_seen = 0;

    load_store_unit #(.DEPTH_LOG2(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: asynchronous read, write on the falling edge
    assign w_idx  = mem_addr[5:0];
    assign mem_rd = mem[w_idx];
    initial begin
        for (int k = 0; k < 64; k++) mem[k] = k + 1;
        forever begin
            @(negedge clk);
            if (mem_we) mem[w_idx] = mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every memory write and response against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                nwr_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", mem_addr, sb[0].wa);
                    chk("wr_data", mem_wd, sb[0].wd);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("latency", cyc - e.acc, e.lat);
                    chk("write_count", nwr_seen, e.nwr);
                end
                nwr_seen = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input exp_t e, input bit push);
        int t;
        t          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.acc = cyc;
            if (push) sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] r, input logic err);
        exp_t e;
        e = '{rdata: r, err: err, lat: (err ? 1 : 2), nwr: 0, wa: 32'h0, wd: 32'h0, acc: 0};
        issue(1'b0, f3, a, 32'h0, e, 1'b1);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic err, input logic [31:0] wa, input logic [31:0] wdx);
        exp_t e;
        e = '{rdata: 32'h0, err: err, lat: (err ? 1 : ((f3[1:0] == 2'b10) ? 2 : 3)),
              nwr: (err ? 0 : 1), wa: wa, wd: wdx, acc: 0};
        issue(1'b1, f3, a, wd, e, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        ld(3'b010, 32'h0000_000C, 32'h0000_0004, 1'b0);
        req_valid = 1'b0;
        drain();
        st(3'b010, 32'h0000_0000, 32'h0000_00F0, 1'b0, 32'd0, 32'h0000_00F0);
        ld(3'b000, 32'h0000_0000, 32'hFFFF_FFF0, 1'b0);
        ld(3'b100, 32'h0000_0000, 32'h0000_00F0, 1'b0);
        st(3'b010, 32'h0000_0008, 32'h8001_0000, 1'b0, 32'd2, 32'h8001_0000);
        ld(3'b001, 32'h0000_000A, 32'hFFFF_8001, 1'b0);
        ld(3'b101, 32'h0000_000A, 32'h0000_8001, 1'b0);
        st(3'b000, 32'h0000_0005, 32'h0000_00AB, 1'b0, 32'd1, 32'h0000_AB02);
        ld(3'b010, 32'h0000_0004, 32'h0000_AB02, 1'b0);
        ld(3'b000, 32'h0000_0005, 32'hFFFF_FFAB, 1'b0);
        st(3'b001, 32'h0000_0003, 32'h0000_1234, 1'b1, 32'd0, 32'h0);
        ld(3'b010, 32'h0000_0100, 32'h0, 1'b1);
        ld(3'b011, 32'h0000_0000, 32'h0, 1'b1);
        st(3'b100, 32'h0000_0000, 32'h0000_0055, 1'b1, 32'd0, 32'h0);
        ld(3'b010, 32'h0000_0002, 32'h0, 1'b1);
        st(3'b001, 32'h0000_000E, 32'h0000_1234, 1'b0, 32'd3, 32'h1234_0004);
        ld(3'b010, 32'h0000_000C, 32'h1234_0004, 1'b0);
        ld(3'b101, 32'h0000_000E, 32'h0000_1234, 1'b0);
        ld(3'b010, 32'h0000_00FC, 32'h0000_0040, 1'b0);
        req_valid = 1'b0;
        drain();

        // Abandon a word store mid-WRITE with an asynchronous reset
        @(negedge clk);
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, exp_t'{32'h0, 1'b0, 2, 1, 32'd4, 32'hDEAD_BEEF, 0}, 1'b0);
        req_valid = 1'b0;
        chk("we_in_write", {31'd0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("we_async_drop", {31'd0, mem_we}, 32'd0);
        chk("ready_in_reset", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("no_resp_in_reset", {31'd0, resp_valid}, 32'd0);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        chk("word4_unchanged", mem[4], 32'h0000_0005);
        chk("no_resp_after_reset", {31'd0, resp_valid}, 32'd0);
        ld(3'b010, 32'h0000_0010, 32'h0000_0005, 1'b0);
        req_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
